// File: rtl/control_register_bank.sv
// Double-buffered control register bank: the host writes shadow copies, and a commit edge
// moves the dirty shadows into the active registers that drive `control`.
module control_register_bank #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] WRITABLE_MASK = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] SELF_CLEAR_MASK = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write,
    input  logic [ADDR_WIDTH-1:0]          write_address,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           commit,
    input  logic                           read,
    input  logic [ADDR_WIDTH-1:0]          read_address,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           read_valid,
    output logic [NUM_REGS*DATA_WIDTH-1:0] control,
    output logic [NUM_REGS-1:0]            updated,
    output logic                           write_error
);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t               wmask [NUM_REGS];
    word_t               scmask [NUM_REGS];
    word_t               rstval [NUM_REGS];
    word_t               shadow_q [NUM_REGS];
    word_t               shadow_d [NUM_REGS];
    word_t               active_q [NUM_REGS];
    word_t               active_d [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q;
    logic [NUM_REGS-1:0] dirty_d;
    logic [NUM_REGS-1:0] updated_d;
    word_t               read_data_d;
    logic                write_q;
    logic                commit_q;
    logic                write_edge;
    logic                commit_edge;
    logic                addr_ok;
    logic                write_error_d;

    // Per-register views of the packed parameter images, and the flattened active output.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_field
        assign wmask[g]  = WRITABLE_MASK[g*DATA_WIDTH +: DATA_WIDTH];
        assign scmask[g] = SELF_CLEAR_MASK[g*DATA_WIDTH +: DATA_WIDTH];
        assign rstval[g] = RESET_VALUE[g*DATA_WIDTH +: DATA_WIDTH]
                         & ~SELF_CLEAR_MASK[g*DATA_WIDTH +: DATA_WIDTH];
        assign control[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

    always_comb begin
        write_edge    = write & ~write_q;
        commit_edge   = commit & ~commit_q;
        addr_ok       = 32'(write_address) < NUM_REGS;
        write_error_d = write_edge & ~addr_ok;
        read_data_d   = '0;
        updated_d     = '0;
        dirty_d       = dirty_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            shadow_d[i] = shadow_q[i];
            // Self-clear bits survive in active for only the cycle they were loaded.
            active_d[i] = active_q[i] & ~scmask[i];
            // Commit sees the shadow from before any same-cycle write.
            if (commit_edge && dirty_q[i]) begin
                active_d[i]  = shadow_q[i];
                shadow_d[i]  = shadow_q[i] & ~scmask[i];
                dirty_d[i]   = 1'b0;
                updated_d[i] = 1'b1;
            end
            if (write_edge && addr_ok && (write_address == ADDR_WIDTH'(i))) begin
                shadow_d[i] = (shadow_q[i] & ~wmask[i]) | (write_data & wmask[i]);
                dirty_d[i]  = 1'b1;
            end
        end
        // Reads return the post-edge active value; out-of-range addresses fall through to 0.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (read_address == ADDR_WIDTH'(i)) begin
                read_data_d = active_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= rstval[i];
                active_q[i] <= rstval[i];
            end
            dirty_q     <= '0;
            write_q     <= 1'b1;
            commit_q    <= 1'b1;
            read_data   <= '0;
            read_valid  <= 1'b0;
            updated     <= '0;
            write_error <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            dirty_q     <= dirty_d;
            write_q     <= write;
            commit_q    <= commit;
            read_data   <= read ? read_data_d : '0;
            read_valid  <= read;
            updated     <= updated_d;
            write_error <= write_error_d;
        end
    end

endmodule

// File: tb/tb_control_register_bank.sv
// Bench for control_register_bank: read results checked through a scoreboard queue,
// control/updated/write_error checked inline against expected constants.
module tb_control_register_bank;

    localparam logic [31:0] RV = 32'h0000_A500;
    localparam logic [31:0] WM = 32'hFFFF_0FFF;
    localparam logic [31:0] SC = 32'h8000_0000;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] due;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        write, commit, read;
    logic [1:0]  write_address, read_address;
    logic [7:0]  write_data, read_data;
    logic        read_valid, write_error;
    logic [31:0] control;
    logic [3:0]  updated;

    logic        e_write, e_commit, e_read;
    logic [2:0]  e_write_address, e_read_address;
    logic [7:0]  e_write_data, e_read_data;
    logic        e_read_valid, e_write_error;
    logic [39:0] e_control;
    logic [4:0]  e_updated;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = '0;
    logic        mon_en = 1'b0;
    rd_t         exp_q[$];

    logic [7:0]  m_sh [4];
    logic [7:0]  m_act [4];
    logic [3:0]  m_dirty;
    logic        m_wprev, m_cprev;

    control_register_bank #(
        .NUM_REGS(4), .DATA_WIDTH(8), .RESET_VALUE(RV),
        .WRITABLE_MASK(WM), .SELF_CLEAR_MASK(SC)
    ) dut (
        .clk(clk), .reset(reset), .write(write), .write_address(write_address),
        .write_data(write_data), .commit(commit), .read(read), .read_address(read_address),
        .read_data(read_data), .read_valid(read_valid), .control(control),
        .updated(updated), .write_error(write_error)
    );

    control_register_bank #(
        .NUM_REGS(5), .DATA_WIDTH(8)
    ) dut_e (
        .clk(clk), .reset(reset), .write(e_write), .write_address(e_write_address),
        .write_data(e_write_data), .commit(e_commit), .read(e_read), .read_address(e_read_address),
        .read_data(e_read_data), .read_valid(e_read_valid), .control(e_control),
        .updated(e_updated), .write_error(e_write_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Scoreboard: each read is due exactly one edge after it was issued.
    always @(negedge clk) begin
        rd_t ent;
        if (mon_en) begin
            checks++;
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                ent = exp_q.pop_front();
                if (read_valid !== 1'b1 || read_data !== ent.data) begin
                    errors++;
                    $display("FAIL read_result: got valid=%b data=%h, expected valid=1 data=%h",
                             read_valid, read_data, ent.data);
                end
            end else if (read_valid !== 1'b0) begin
                errors++;
                $display("FAIL read_idle: got valid=%b data=%h, expected valid=0",
                         read_valid, read_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 8'(RV >> (8 * i)) & ~8'(SC >> (8 * i));
            m_act[i] = m_sh[i];
        end
        m_dirty = '0;
        m_wprev = 1'b1;
        m_cprev = 1'b1;
    endtask

    // Drive one cycle of main-DUT stimulus, advance the reference model, queue any read.
    task automatic step(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                        input logic c, input logic r, input logic [1:0] ra);
        logic       we, ce;
        logic [7:0] wmv, scv;
        write = w; write_address = wa; write_data = wd;
        commit = c; read = r; read_address = ra;
        we = w && !m_wprev;
        ce = c && !m_cprev;
        m_wprev = w;
        m_cprev = c;
        for (int i = 0; i < 4; i++) m_act[i] = m_act[i] & ~8'(SC >> (8 * i));
        if (ce) begin
            for (int i = 0; i < 4; i++) begin
                if (m_dirty[i]) begin
                    m_act[i]   = m_sh[i];
                    m_sh[i]    = m_sh[i] & ~8'(SC >> (8 * i));
                    m_dirty[i] = 1'b0;
                end
            end
        end
        if (we) begin
            wmv = 8'(WM >> (8 * wa));
            m_sh[wa] = (m_sh[wa] & ~wmv) | (wd & wmv);
            m_dirty[wa] = 1'b1;
        end
        scv = '0;
        if (r) exp_q.push_back('{data: m_act[ra] | scv, due: cyc + 32'd1});
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        write = 0; commit = 0; read = 0; write_address = 0; read_address = 0; write_data = 0;
        e_write = 0; e_commit = 0; e_read = 0; e_write_address = 0; e_read_address = 0; e_write_data = 0;
        tick();
        tick();
        checks++;
        if (control !== 32'h0000_A500) begin errors++; $display("FAIL reset_control: got %h expected 0000a500", control); end
        checks++;
        if (updated !== 4'b0 || write_error !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got updated=%b write_error=%b expected 0/0", updated, write_error);
        end
        checks++;
        if (read_valid !== 1'b0 || read_data !== 8'h00) begin
            errors++; $display("FAIL reset_read: got valid=%b data=%h expected 0/00", read_valid, read_data);
        end
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        step(0, 0, 0, 0, 1, 2'd1);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_write_commit();
        step(1, 2'd0, 8'h3C, 0, 0, 0);
        checks++;
        if (control !== 32'h0000_A500) begin errors++; $display("FAIL write_no_commit: got %h expected 0000a500", control); end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2'd0);
        checks++;
        if (control[7:0] !== 8'h3C || updated !== 4'b0001) begin
            errors++; $display("FAIL commit_reg0: got ctl=%h upd=%b expected 3c/0001", control[7:0], updated);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (updated !== 4'b0000) begin errors++; $display("FAIL updated_one_cycle: got %b expected 0000", updated); end
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (updated !== 4'b0000 || control !== 32'h0000_A53C) begin
            errors++; $display("FAIL clean_commit: got upd=%b ctl=%h expected 0000/0000a53c", updated, control);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_readonly();
        step(1, 2'd1, 8'hFF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (control[15:8] !== 8'hAF || updated !== 4'b0010) begin
            errors++; $display("FAIL readonly_nibble: got ctl=%h upd=%b expected af/0010", control[15:8], updated);
        end
        step(0, 0, 0, 0, 1, 2'd1);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_self_clear();
        step(1, 2'd3, 8'h81, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2'd3);
        checks++;
        if (control[31:24] !== 8'h81 || updated !== 4'b1000) begin
            errors++; $display("FAIL self_clear_load: got ctl=%h upd=%b expected 81/1000", control[31:24], updated);
        end
        step(0, 0, 0, 0, 1, 2'd3);
        checks++;
        if (control[31:24] !== 8'h01) begin errors++; $display("FAIL self_clear_drop: got %h expected 01", control[31:24]); end
        step(1, 2'd2, 8'h55, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2'd3);
        checks++;
        if (control !== 32'h0155_AF3C || updated !== 4'b0100) begin
            errors++; $display("FAIL self_clear_recommit: got ctl=%h upd=%b expected 0155af3c/0100", control, updated);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_write_hold();
        step(1, 2'd0, 8'h11, 0, 0, 0);
        for (int k = 0; k < 9; k++) step(1, 2'd0, 8'h20 + 8'(k), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2'd0);
        checks++;
        if (control[7:0] !== 8'h11) begin errors++; $display("FAIL write_hold_once: got %h expected 11", control[7:0]); end
        step(0, 0, 0, 0, 0, 0);
        step(1, 2'd0, 8'h22, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (control[7:0] !== 8'h22) begin errors++; $display("FAIL write_rearm: got %h expected 22", control[7:0]); end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        step(1, 2'd0, 8'h44, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 2'd0, 8'h66, 1, 1, 2'd0);
        checks++;
        if (control[7:0] !== 8'h44 || updated !== 4'b0001) begin
            errors++; $display("FAIL same_cycle_old: got ctl=%h upd=%b expected 44/0001", control[7:0], updated);
        end
        step(0, 0, 0, 0, 1, 2'd1);
        checks++;
        if (control[7:0] !== 8'h44 || updated !== 4'b0000) begin
            errors++; $display("FAIL same_cycle_hold: got ctl=%h upd=%b expected 44/0000", control[7:0], updated);
        end
        step(0, 0, 0, 1, 1, 2'd0);
        checks++;
        if (control[7:0] !== 8'h66 || updated !== 4'b0001) begin
            errors++; $display("FAIL same_cycle_new: got ctl=%h upd=%b expected 66/0001", control[7:0], updated);
        end
        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, 1, 2'(a));
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_write_error();
        e_write = 1; e_write_address = 3'd5; e_write_data = 8'hAA;
        tick();
        checks++;
        if (e_write_error !== 1'b1) begin errors++; $display("FAIL write_error_pulse: got %b expected 1", e_write_error); end
        tick();
        checks++;
        if (e_write_error !== 1'b0) begin errors++; $display("FAIL write_error_width: got %b expected 0", e_write_error); end
        e_write = 0; e_commit = 1;
        tick();
        checks++;
        if (e_updated !== 5'b0 || e_control !== 40'h0) begin
            errors++; $display("FAIL write_error_nostate: got upd=%b ctl=%h expected 0/0", e_updated, e_control);
        end
        e_commit = 0; e_write = 1; e_write_address = 3'd4; e_write_data = 8'h5A;
        tick();
        checks++;
        if (e_write_error !== 1'b0) begin errors++; $display("FAIL write_in_range_err: got %b expected 0", e_write_error); end
        e_write = 0; e_commit = 1;
        tick();
        checks++;
        if (e_control[39:32] !== 8'h5A || e_updated !== 5'b10000 || e_read_valid !== 1'b0) begin
            errors++; $display("FAIL wide_commit: got ctl=%h upd=%b rv=%b expected 5a/10000/0",
                               e_control[39:32], e_updated, e_read_valid);
        end
        e_commit = 0;
        tick();
    endtask

    task automatic test_reset_hold();
        reset = 1'b1;
        write = 1; write_address = 2'd0; write_data = 8'h99; commit = 1; read = 0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        step(1, 2'd0, 8'h99, 1, 0, 0);
        checks++;
        if (updated !== 4'b0 || control !== 32'h0000_A500) begin
            errors++; $display("FAIL reset_hold_first: got upd=%b ctl=%h expected 0/0000a500", updated, control);
        end
        step(1, 2'd0, 8'h99, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2'd0);
        checks++;
        if (updated !== 4'b0 || control !== 32'h0000_A500) begin
            errors++; $display("FAIL reset_hold_nowrite: got upd=%b ctl=%h expected 0/0000a500", updated, control);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_readonly();
        test_self_clear();
        test_write_hold();
        test_back_to_back();
        test_write_error();
        test_reset_hold();
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL read_drain: got %0d pending expected 0", exp_q.size()); end
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_register_bank.md
CONTROL_REGISTER_BANK -- requirements
Module: control_register_bank

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports `clk` and `reset`.
REQ-002 Parameters SHALL be:
- NUM_REGS, 8: number of control registers (2..64).
- DATA_WIDTH, 8: bits per register (1..32).
- ADDR_WIDTH, $clog2(NUM_REGS): address width.
- RESET_VALUE, '0: NUM_REGS*DATA_WIDTH packed reset image; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- WRITABLE_MASK, all ones: packed image; 0 bits are read-only and keep their reset value.
- SELF_CLEAR_MASK, '0: packed image; 1 bits are single-cycle pulses after commit.
REQ-003 Ports SHALL be:
- clk, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- write, in, 1: level; its rising edge requests a shadow write.
- write_address, in, ADDR_WIDTH: target register for the write.
- write_data, in, DATA_WIDTH: value for the write.
- commit, in, 1: level; its rising edge copies shadow to active.
- read, in, 1: read request, sampled every cycle.
- read_address, in, ADDR_WIDTH: register to read.
- read_data, out, DATA_WIDTH: active value of the addressed register.
- read_valid, out, 1: read_data is valid this cycle.
- control, out, NUM_REGS*DATA_WIDTH: flattened active registers.
- updated, out, NUM_REGS: one-cycle pulse per register loaded by commit.
- write_error, out, 1: one-cycle pulse on an out-of-range write.

Function
REQ-004 The block SHALL hold two copies of each register: shadow (written by the host) and active (drives `control`).
REQ-005 A write edge SHALL be detected when `write`=1 this cycle and the registered `write` was 0; commit edges SHALL be detected the same way.
REQ-006 On a write edge with write_address < NUM_REGS, the block SHALL update that shadow at this clock edge:
- writable bits (WRITABLE_MASK=1) take write_data;
- other bits keep their value;
- the register's dirty bit is set.
REQ-007 On a write edge with write_address >= NUM_REGS, the block SHALL leave shadow and dirty unchanged and assert write_error for exactly the next cycle.
REQ-008 `write` held high SHALL produce exactly one write; a new write requires `write` to return to 0 for at least one cycle.
REQ-009 On a commit edge, for every register whose dirty bit is set, the block SHALL:
- copy shadow to active at this clock edge;
- clear the dirty bit;
- pulse updated[i] for exactly the next cycle.
Clean registers SHALL keep their active value and SHALL NOT pulse.
REQ-010 Self-clear bits: a self-clear bit loaded as 1 by a commit SHALL read 1 in active for exactly one cycle, then return to 0. The matching shadow bit SHALL be cleared to 0 in the same cycle as the commit.
REQ-011 When a write edge and a commit edge occur in the same cycle, the commit SHALL use the shadow value from before the write. The new write SHALL land in shadow and remain dirty for the next commit.
REQ-012 When read=1 in cycle N, read_data SHALL present active[read_address] in cycle N+1 with read_valid=1.
- An address >= NUM_REGS SHALL return 0 with read_valid=1.
- read_valid SHALL be 0 in any cycle not preceded by read=1.
- Back-to-back reads SHALL give one result per cycle.
REQ-013 Reads SHALL return the active value as it is after the cycle-N clock edge, so a read in the same cycle as a commit returns the committed value.
REQ-014 `control` SHALL be driven directly from the active registers, with no additional latency.

Reset
REQ-015 On reset=1 at a clock edge, the block SHALL:
- load shadow and active from RESET_VALUE, with self-clear bits forced to 0;
- clear all dirty bits;
- drive read_valid=0, read_data=0, updated=0, write_error=0.
REQ-016 During reset, the registered `write` and `commit` samples SHALL load 1, so a level held high through reset produces no edge after release.
REQ-017 A write or commit edge coinciding with reset SHALL be discarded.

Verification (NUM_REGS=4, DATA_WIDTH=8, RESET_VALUE=0x00_00_A5_00, WRITABLE_MASK=0xFF_FF_0F_FF, SELF_CLEAR_MASK=0x80_00_00_00)
REQ-018 Reset, then read addr 1 -> read_data=0xA5, read_valid=1 one cycle later; control=0x0000A500.
REQ-019 Write 0x3C to addr 0, no commit -> control unchanged. Commit edge -> control[7:0]=0x3C, updated=0001 for one cycle. Second commit -> no updated pulse.
REQ-020 Write 0xFF to addr 1, commit -> active[1]=0xAF (upper nibble read-only).
REQ-021 Write 0x81 to addr 3, commit -> active[3]=0x81 for one cycle, then 0x01; shadow[3] reads back 0x01 on the next commit.
REQ-022 Write to addr 5 (ADDR_WIDTH=2 with a widened test parameter, NUM_REGS=5 to 8 cases) -> write_error pulse, no state change. Write held high 10 cycles -> one write. Write and commit edges in the same cycle -> old shadow committed, new value committed on the next commit.
REQ-023 Hold write=1 and commit=1 through reset release -> no write, no commit, updated=0.
